// File: rtl/calc_entry_pkg.sv
// calc_entry_pkg: FSM states, ASCII key constants and key-grid helpers
package calc_entry_pkg;
  typedef enum logic [1:0] {S_OP1, S_OP2, S_DONE} state_t;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CE = 8'h3f;
  localparam logic [7:0] EXEC = 8'h3e;
  localparam logic [7:0] CLR = 8'h21;
  localparam int GRID_W = 6;
  localparam int GRID_H = 4;
  localparam int N_KEYS = GRID_W * GRID_H;
  localparam logic [8*N_KEYS-1:0] KEYS = "0123+-4567*|89AB&?CDEF>!";

  function automatic logic [7:0] key_at(input logic [4:0] idx);
    return (int'(idx) < N_KEYS) ? KEYS[8*(N_KEYS-1-int'(idx)) +: 8] : SPACE;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
  endfunction

  function automatic logic is_operator(input logic [7:0] c);
    return c == "+" || c == "-" || c == "*" || c == "|" || c == "&";
  endfunction
endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: registered rising-edge pulse for one debounced button;
// with CALC_ENTRY_AUTOREPEAT_EN a held button also pulses every REPEAT_CYCLES cycles.
module btn_edge_detect
`ifdef CALC_ENTRY_AUTOREPEAT_EN
  #(
  parameter int REPEAT_CYCLES = 12500000,
  parameter bit REPEAT_EN = 1'b1
)
`endif
  (
  input logic clk,
  input logic rst,
  input logic btn,
  output logic pulse
);
  logic btn_q;
`ifdef CALC_ENTRY_AUTOREPEAT_EN
  localparam int CW = $clog2(REPEAT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = REPEAT_EN && btn && btn_q && cnt == CW'(REPEAT_CYCLES - 1);
  // counter restarts on the edge so the first repeat lands REPEAT_CYCLES after it
  always_ff @(posedge clk) begin
    btn_q <= rst ? 1'b0 : btn;
    pulse <= !rst && btn && (!btn_q || hit);
    cnt <= (rst || !REPEAT_EN || !btn || !btn_q || hit) ? '0 : cnt + 1'b1;
  end
`else
  always_ff @(posedge clk) begin
    btn_q <= rst ? 1'b0 : btn;
    pulse <= !rst && btn && !btn_q;
  end
`endif
endmodule

// File: rtl/calc_entry_controller.sv
// calc_entry_controller: keypad cursor + expression entry feeding the template renderer.
// Optional macro CALC_ENTRY_AUTOREPEAT_EN enables auto-repeat on held direction buttons.
module calc_entry_controller
  import calc_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 5,
  parameter int REPEAT_CYCLES = 12500000
) (
  input logic clk_vga,
  input logic rst,
  input logic btn_up,
  input logic btn_down,
  input logic btn_left,
  input logic btn_right,
  input logic btn_press,
  output logic [4:0] cursor_idx,
  output logic [7:0] key_char,
  output logic [79:0] calculator_value_entry,
  output logic [39:0] operando1_entry,
  output logic [39:0] operando2_entry,
  output logic [7:0] operacion,
  output logic calc_start
);
  if (MAX_DIGITS < 1 || MAX_DIGITS > 5 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("calc_entry_controller: MAX_DIGITS must be 1..5 and REPEAT_CYCLES >= 1");
  end

  localparam logic [79:0] SP10 = {10{SPACE}};
  localparam logic [39:0] SP5 = {5{SPACE}};

  logic [4:0] btn, pulse;
  logic [2:0] x, x_n;
  logic [1:0] y, y_n;
  state_t state, state_n;
  logic [79:0] entry_n;
  logic [39:0] op1_n, op2_n;
  logic [7:0] oper_n;
  logic [2:0] cnt, cnt_n;
  logic start_n, dig, wipe;

  // bit order doubles as priority: press > up > down > left > right
  assign btn = {btn_press, btn_up, btn_down, btn_left, btn_right};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_edge_detect
`ifdef CALC_ENTRY_AUTOREPEAT_EN
      #(.REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(i != 4))
`endif
      u_btn (.clk(clk_vga), .rst(rst), .btn(btn[i]), .pulse(pulse[i]));
  end

  assign cursor_idx = 5'(y) * 5'd6 + 5'(x);
  assign key_char = key_at(cursor_idx);
  assign dig = is_digit(key_char);
  assign wipe = key_char == CLR || (state == S_DONE && dig);

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      state <= S_OP1;
      calculator_value_entry <= SP10;
      operando1_entry <= SP5;
      operando2_entry <= SP5;
      operacion <= SPACE;
      cnt <= '0;
      calc_start <= 1'b0;
    end else begin
      x <= x_n;
      y <= y_n;
      state <= state_n;
      calculator_value_entry <= entry_n;
      operando1_entry <= op1_n;
      operando2_entry <= op2_n;
      operacion <= oper_n;
      cnt <= cnt_n;
      calc_start <= start_n;
    end
  end

  always_comb begin
    x_n = x;
    y_n = y;
    state_n = state;
    entry_n = calculator_value_entry;
    op1_n = operando1_entry;
    op2_n = operando2_entry;
    oper_n = operacion;
    cnt_n = cnt;
    start_n = 1'b0;
    if (pulse[4]) begin
      if (wipe) begin
        // a digit after a finished expression starts operand 1 in the same cycle
        state_n = S_OP1;
        entry_n = dig ? {SP10[79:8], key_char} : SP10;
        op1_n = SP5;
        op2_n = SP5;
        oper_n = SPACE;
        cnt_n = dig ? 3'd1 : 3'd0;
      end else if (state != S_DONE) begin
        if (key_char == CE) begin
          entry_n = SP10;
          cnt_n = '0;
        end else if (dig) begin
          entry_n = (cnt < 3'(MAX_DIGITS)) ? {calculator_value_entry[71:0], key_char} : calculator_value_entry;
          cnt_n = (cnt < 3'(MAX_DIGITS)) ? cnt + 3'd1 : cnt;
        end else if (is_operator(key_char) && state == S_OP1 && cnt != 0) begin
          op1_n = calculator_value_entry[39:0];
          oper_n = key_char;
          entry_n = SP10;
          cnt_n = '0;
          state_n = S_OP2;
        end else if (is_operator(key_char) && state == S_OP2 && cnt == 0) begin
          oper_n = key_char;
        end else if (key_char == EXEC && state == S_OP2 && cnt != 0) begin
          op2_n = calculator_value_entry[39:0];
          start_n = 1'b1;
          state_n = S_DONE;
        end
      end
    end else if (pulse[3]) begin
      y_n = (y == 2'd0) ? 2'(GRID_H - 1) : y - 2'd1;
    end else if (pulse[2]) begin
      y_n = (y == 2'(GRID_H - 1)) ? 2'd0 : y + 2'd1;
    end else if (pulse[1]) begin
      x_n = (x == 3'd0) ? 3'(GRID_W - 1) : x - 3'd1;
    end else if (pulse[0]) begin
      x_n = (x == 3'(GRID_W - 1)) ? 3'd0 : x + 3'd1;
    end
  end
endmodule

// File: doc/calc_entry_controller.md
Name: calc_entry_controller

Overview:
- Keypad/entry controller directly upstream of the template renderer.
- Moves a cursor over the 6x4 on-screen key grid using direction buttons, and executes the selected key on a press.
- Builds the ASCII buffers the renderer draws:
  - 10-char entry line
  - operand 1 and operand 2 (5 chars each)
  - operator char
- Pulses calc_start when an expression is complete.

Parameters:
- MAX_DIGITS, 5, maximum hex digits per operand. Must be ≤5.
- REPEAT_CYCLES, 12500000, hold time before and between auto-repeat steps. Used only with the optional feature.

Ports:
- clk_vga  in  1  pixel clock, sole clock
- rst  in  1  synchronous, active-high reset
- btn_up, btn_down, btn_left, btn_right, btn_press  in  1 each  debounced level inputs
- cursor_idx  out  5  selected key, y*6+x (0..23); matches the renderer's square index
- key_char  out  8  ASCII of the key under the cursor (combinational from cursor)
- calculator_value_entry  out  80  entry line; char0 at [79:72]
- operando1_entry  out  40  operand 1 ASCII
- operando2_entry  out  40  operand 2 ASCII
- operacion  out  8  operator ASCII
- calc_start  out  1  one-cycle pulse, operands valid

Behaviour:
- Key grid, row-major, x 0..5, y 0..3:
  - row 0: "0123+-"
  - row 1: "4567*|"
  - row 2: "89AB&?"
  - row 3: "CDEF>!"
- Key classes:
  - digits: 0-9, A-F
  - operators: + - * | &
  - '?' = clear entry (CE)
  - '>' = execute
  - '!' = clear all
- Reset / clear-all values:
  - cursor (0,0), so cursor_idx=0 and key_char="0"
  - all buffers filled with 0x20 (space)
  - operacion=0x20, calc_start=0
  - digit count=0, state S_OP1
- Buttons: registered rising-edge detect.
  - An action occurs the cycle after the edge is sampled.
  - Simultaneous edges: only the highest priority acts (press > up > down > left > right); the rest are dropped.
- Cursor moves wrap around: x 5→0 and 0→5; y 3→0 and 0→3.
- Digit entry: if count < MAX_DIGITS, shift the entry line left one char, insert the digit at [7:0], count++. Otherwise ignore the digit.
- Entry line is right-aligned. Operands capture the low 40 bits of the entry line.
- FSM states: S_OP1, S_OP2, S_DONE.
- S_OP1:
  - digit: shift in
  - operator with count≥1: operando1_entry←entry[39:0], operacion←key, clear entry, count=0, go to S_OP2
  - operator with count=0: ignored
  - '>': ignored
- S_OP2:
  - digit: shift in
  - operator with count=0: replace operacion
  - operator with count≥1: ignored
  - '>' with count≥1: operando2_entry←entry[39:0], calc_start=1 for exactly one cycle, go to S_DONE
  - '>' with count=0: ignored
- S_DONE:
  - digit: all buffers and operacion cleared; digit becomes first char of operand 1; go to S_OP1 (single cycle)
  - operator, '>', '?': ignored
  - operands stay displayed until the next digit
- '?' in S_OP1/S_OP2: entry←spaces, count=0, state unchanged.
- '!' in any state: all reset values except the cursor, which is kept.
- rst mid-entry: full reset next edge; any pending edge is discarded; calc_start is never emitted from a partial expression.
- Outputs are registered except key_char/cursor_idx, which are combinational from the cursor registers.

Optional Feature:
- Macro: CALC_ENTRY_AUTOREPEAT_EN.
- Defined:
  - A direction button held continuously gives one step on the edge.
  - Then one further step each REPEAT_CYCLES cycles while held.
  - Counter clears on release or rst.
  - btn_press never repeats.
- Undefined: edge-only movement; no repeat counter is synthesized.

Decomposition:
- Package calc_entry_pkg:
  - state enum {S_OP1, S_OP2, S_DONE}
  - ASCII constants: SPACE, CE '?', EXEC '>', CLR '!'
  - GRID_W=6, GRID_H=4
  - function key_at(idx)→ASCII
  - functions is_digit(), is_operator()
- Sub-module btn_edge_detect: per-button registered rising edge, plus the repeat counter under the macro. Instantiate 5 times.

Test Plan:
- Reset → cursor_idx=0, key_char=0x30, entry=80'h2020…20, operacion=0x20, calc_start=0.
- left from (0,0) → cursor_idx=5, key_char="-"; up from (0,0) → cursor_idx=18, key_char="C".
- Press 1,A,+,3,'>' → operando1_entry=40'h2020203141, operacion="+", operando2_entry=40'h2020202033, one-cycle calc_start, state S_DONE.
- Six digit presses "123456" → entry low 40 bits = "12345"; sixth digit ignored; '?' → entry all 0x20.
- Press '+' in S_OP1 with count=0 → no change. In S_OP2, '+' then '*' with count=0 → operacion="*".
- Edges on btn_press and btn_up in the same cycle → only the press acts; cursor unchanged. With CALC_ENTRY_AUTOREPEAT_EN and REPEAT_CYCLES=4, hold right 13 cycles → exactly 4 steps.
